// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module mdu_iter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic         kill,
   input  logic [2:0]   op,
   input  logic [W-1:0] src1,
   input  logic [W-1:0] src2,
   output logic         busy,
   output logic         fin,
   output logic [W-1:0] result
);

   localparam int unsigned CW = $clog2(W + 1);
   localparam int unsigned PW = 2 * W;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic            sa_q, sa_d, sb_q, sb_d;
   logic [W-1:0]    opnd_q, opnd_d;
   logic [PW-1:0]   prod_q, prod_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    result_q, result_d;
   logic            busy_q, busy_d, fin_q, fin_d;

   // Acceptance-side decode: signs, magnitudes and fast-path detection
   logic            is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
   logic [W-1:0]    mag_a, mag_b, fast_res;

   // Iteration and sign-fix datapath; prod_q holds {rem, quo} while dividing
   logic [W:0]      mul_sum, div_sh, div_diff;
   logic [PW-1:0]   calc_prod, prod_neg, mul_p;
   logic [W-1:0]    quo_fix, rem_fix, fix_res;

   always_comb begin
      is_div   = op[2];
      sgn_a    = is_div ? ~op[0] : (op != 3'b011);
      sgn_b    = is_div ? ~op[0] : ~op[1];
      neg_a    = sgn_a & src1[W-1];
      neg_b    = sgn_b & src2[W-1];
      mag_a    = neg_a ? (~src1 + W'(1)) : src1;
      mag_b    = neg_b ? (~src2 + W'(1)) : src2;
      div_zero = (src2 == '0);
      div_ovf  = ~op[0] & (src1 == MIN_NEG) & (&src2);
      if (div_zero) fast_res = op[1] ? src1 : '1;
      else          fast_res = op[1] ? '0 : src1;

      mul_sum  = {1'b0, prod_q[PW-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      div_sh   = {prod_q[PW-1:W], prod_q[W-1]};
      div_diff = div_sh - {1'b0, opnd_q};
      if (!op_q[2])        calc_prod = {mul_sum, prod_q[W-1:1]};
      else if (div_diff[W]) calc_prod = {div_sh[W-1:0], prod_q[W-2:0], 1'b0};
      else                 calc_prod = {div_diff[W-1:0], prod_q[W-2:0], 1'b1};

      prod_neg = ~prod_q + PW'(1);
      mul_p    = (sa_q ^ sb_q) ? prod_neg : prod_q;
      quo_fix  = (sa_q ^ sb_q) ? (~prod_q[W-1:0] + W'(1)) : prod_q[W-1:0];
      rem_fix  = sa_q ? (~prod_q[PW-1:W] + W'(1)) : prod_q[PW-1:W];
      if (op_q[2])             fix_res = op_q[1] ? rem_fix : quo_fix;
      else if (op_q == 3'b000) fix_res = mul_p[W-1:0];
      else                     fix_res = mul_p[PW-1:W];
   end

   // Next-state and datapath updates; kill overrides everything
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      opnd_d   = opnd_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (kill) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_d   = op;
                  sa_d   = neg_a;
                  sb_d   = neg_b;
                  cnt_d  = '0;
                  opnd_d = is_div ? mag_b : mag_a;
                  prod_d = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                  if (is_div && (div_zero || div_ovf)) begin
                     result_d = fast_res;
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_CALC;
                  end
               end
            end
            S_CALC: begin
               prod_d = calc_prod;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CW'(W - 1)) state_d = S_FIX;
            end
            S_FIX: begin
               result_d = fix_res;
               state_d  = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
      fin_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         opnd_q   <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         opnd_q   <= opnd_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         fin_q    <= fin_d;
      end
   end

   assign busy   = busy_q;
   assign fin    = fin_q;
   assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed ops push expected result and fin cycle,
// an independent monitor checks every fin pulse against the queue.
module tb_mdu_iter;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rstn, start, kill;
   logic [2:0]   op;
   logic [W-1:0] src1, src2;
   logic         busy, fin;
   logic [W-1:0] result;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] res;
      int          fin_cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   mdu_iter #(.W(W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .kill(kill), .op(op),
      .src1(src1), .src2(src2), .busy(busy), .fin(fin), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every fin pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (rstn && fin) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_fin: got fin=1 result %h expected no fin (cycle %0d)", result, cyc);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_result"}, result, mon_e.res);
            check({mon_e.name, "_fin_cycle"}, 32'(cyc), 32'(mon_e.fin_cyc));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
      @(negedge clk);
      op = o; src1 = a; src2 = b; start = 1'b1;
      sb.push_back('{exp, cyc + lat, name});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) return;
      end
      checks++;
      failures++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
   endtask

   initial begin
      int c;
      logic [31:0] r0;
      rstn = 1'b0; start = 1'b0; kill = 1'b0; op = '0; src1 = '0; src2 = '0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_fin", 32'(fin), 32'd0);
      check("reset_result", result, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // MUL timing with busy window
      @(negedge clk);
      c = cyc;
      op = 3'b000; src1 = 32'd7; src2 = 32'hFFFF_FFFD; start = 1'b1;
      sb.push_back('{32'hFFFF_FFEB, c + 34, "mul_7_m3"});
      for (int i = 1; i <= 35; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         check($sformatf("mul_busy_c%0d", i), 32'(busy), (i <= 34) ? 32'd1 : 32'd0);
      end
      wait_idle();

      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");       wait_idle();
      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");        wait_idle();
      issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, "mulhsu");      wait_idle();
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");            wait_idle();
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");            wait_idle();
      issue(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");                       wait_idle();
      issue(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");                        wait_idle();

      // Fast path
      issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");                     wait_idle();
      issue(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_by0");                              wait_idle();
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");      wait_idle();
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");      wait_idle();

      // Kill mid-divide, then a fresh MUL
      @(negedge clk);
      c = cyc; r0 = result;
      op = 3'b100; src1 = 32'hFFFF_FFF9; src2 = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_busy", 32'(busy), 32'd0);
      check("kill_fin", 32'(fin), 32'd0);
      check("kill_result_held", result, r0);
      check("kill_cycle", 32'(cyc), 32'(c + 11));
      issue(3'b000, 32'd3, 32'd4, 32'd12, 34, "mul_after_kill");
      wait_idle();

      // kill and start together in IDLE: nothing accepted
      @(negedge clk);
      op = 3'b000; src1 = 32'd2; src2 = 32'd2; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("kill_start_busy", 32'(busy), 32'd0);

      // start held through fin: exactly one operation
      @(negedge clk);
      c = cyc;
      op = 3'b101; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
      sb.push_back('{32'd14, c + 34, "held_divu"});
      repeat (34) @(negedge clk);
      check("held_fin_seen", 32'(fin), 32'd1);
      @(negedge clk);
      start = 1'b0;
      check("held_busy_after", 32'(busy), 32'd0);
      @(negedge clk);
      check("held_busy_after2", 32'(busy), 32'd0);
      wait_idle();

      // Asynchronous reset mid-operation
      @(negedge clk);
      c = cyc;
      op = 3'b000; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_fin", 32'(fin), 32'd0);
      check("rst_mid_result", result, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_idle_busy", 32'(busy), 32'd0);

      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_post_rst");
      wait_idle();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
